// File: rtl/register_sequencer.sv
// register_sequencer
//   Accepts one command at a time and sequences the one-hot control strobes
//   of a 4-bit clear/load/inc/dec/shift register. It carries out
//   multi-cycle operations: add/sub by N, shift by N, and rotate right by N.
//   Completion is reported with a one-cycle done pulse. The aborted output
//   qualifies that pulse.
//
// Ports
//   clk, rst                : clock and asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready : command handshake
//   i_cmd_op                : 0 NOP, 1 CLR, 2 LOAD, 3 ADD, 4 SUB, 5 SHR, 6 SHL, 7 ROR
//   i_cmd_data              : load value, or repeat count N for ops 3-7
//   i_cmd_fill              : serial fill bit for SHR/SHL
//   i_abort                 : terminate the running command
//   i_reg_q                 : current register contents (bit 0 feeds ROR)
//   o_reg_cl .. o_reg_sl    : register control strobes (at most one high)
//   o_reg_in, o_reg_ir/il   : parallel-load data and serial inputs
//   o_done, o_aborted       : completion pulse and abort qualifier
module register_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [3:0]       i_cmd_data,
  input  logic             i_cmd_fill,
  input  logic             i_abort,
  input  logic [3:0]       i_reg_q,
  output logic             o_reg_cl,
  output logic             o_reg_ld,
  output logic             o_reg_inc,
  output logic             o_reg_dec,
  output logic             o_reg_sr,
  output logic             o_reg_sl,
  output logic [3:0]       o_reg_in,
  output logic             o_reg_ir,
  output logic             o_reg_il,
  output logic             o_done,
  output logic             o_aborted
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_CLR  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ROR  = OP_W'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [OP_W-1:0]    r_op;
  logic [DATA_W-1:0]  r_data;
  logic               r_fill;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_next_count;
  logic [CNT_W-1:0]   w_init_count;
  logic               r_aborted;
  logic               w_next_aborted;
  logic               w_accept;
  logic               w_strobe_en;
  logic               w_unused;

  // Only bit 0 of the register is needed (ROR feedback).
  assign w_unused = ^i_reg_q[3:1];

  assign w_accept    = (r_state == S_IDLE) && i_cmd_valid;
  // An abort in an EXEC cycle kills that cycle's strobe.
  assign w_strobe_en = (r_state == S_EXEC) && !i_abort;

  // Number of strobes a freshly accepted command needs.
  always_comb begin
    w_init_count = '0;
    case (i_cmd_op)
      OP_NOP:           w_init_count = '0;
      OP_CLR, OP_LOAD:  w_init_count = CNT_W'(1);
      default:          w_init_count = CNT_W'(i_cmd_data);
    endcase
  end

  // State, count and abort-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_aborted <= w_next_aborted;
    end
  end

  // Command fields are captured on acceptance and held for the whole command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= OP_NOP;
      r_data <= '0;
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_op   <= i_cmd_op;
      r_data <= i_cmd_data;
      r_fill <= i_cmd_fill;
    end
  end

  // Next-state and count logic.
  always_comb begin
    w_next_state   = r_state;
    w_next_count   = r_count;
    w_next_aborted = r_aborted;
    case (r_state)
      S_IDLE: begin
        w_next_aborted = 1'b0;
        if (w_accept) begin
          w_next_count = w_init_count;
          w_next_state = (w_init_count != '0) ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        if (i_abort) begin
          w_next_count   = '0;
          w_next_aborted = 1'b1;
          w_next_state   = S_DONE;
        end else begin
          w_next_count = r_count - CNT_W'(1);
          // Count of 1 means this cycle's strobe is the last one.
          if (r_count <= CNT_W'(1)) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next_count   = '0;
        w_next_aborted = 1'b0;
        w_next_state   = S_IDLE;
      end
      default: begin
        w_next_count   = '0;
        w_next_aborted = 1'b0;
        w_next_state   = S_IDLE;
      end
    endcase
  end

  // Strobe decode: one strobe per EXEC cycle, data/serial inputs zero otherwise.
  always_comb begin
    o_reg_cl  = 1'b0;
    o_reg_ld  = 1'b0;
    o_reg_inc = 1'b0;
    o_reg_dec = 1'b0;
    o_reg_sr  = 1'b0;
    o_reg_sl  = 1'b0;
    o_reg_in  = '0;
    o_reg_ir  = 1'b0;
    o_reg_il  = 1'b0;
    if (w_strobe_en) begin
      case (r_op)
        OP_CLR:  o_reg_cl = 1'b1;
        OP_LOAD: begin
          o_reg_ld = 1'b1;
          o_reg_in = r_data;
        end
        OP_ADD:  o_reg_inc = 1'b1;
        OP_SUB:  o_reg_dec = 1'b1;
        OP_SHR: begin
          o_reg_sr = 1'b1;
          o_reg_ir = r_fill;
        end
        OP_SHL: begin
          o_reg_sl = 1'b1;
          o_reg_il = r_fill;
        end
        OP_ROR: begin
          // Rotate: bit 0 re-enters at the top, sampled live each cycle.
          o_reg_sr = 1'b1;
          o_reg_ir = i_reg_q[0];
        end
        default: ;
      endcase
    end
  end

  // Handshake and completion decode from the state register.
  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_aborted   = (r_state == S_DONE) && r_aborted;

endmodule

// File: tb/tb_register_sequencer.sv
// Testbench for register_sequencer: a behavioural 4-bit register is
// attached to the strobes. Expected strobe/done events are queued when each
// command is issued. A monitor compares them as the DUT presents them.
module tb_register_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_fill, abort;
  logic [3:0] reg_q = 4'h0;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
  logic [3:0] reg_in;
  logic       reg_ir, reg_il, done, aborted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int abort_cyc = -1;
  int mv = 0;            // model register value after all issued commands
  bit chk_ready_next = 0;

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [5:0] strb;    // {cl,ld,inc,dec,sr,sl}
    logic [3:0] rin;
    logic       ir;
    logic       il;
    logic       ab;
    logic [3:0] val;
  } exp_t;

  exp_t sbq[$];

  register_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data), .i_cmd_fill(cmd_fill),
    .i_abort(abort), .i_reg_q(reg_q),
    .o_reg_cl(reg_cl), .o_reg_ld(reg_ld), .o_reg_inc(reg_inc),
    .o_reg_dec(reg_dec), .o_reg_sr(reg_sr), .o_reg_sl(reg_sl),
    .o_reg_in(reg_in), .o_reg_ir(reg_ir), .o_reg_il(reg_il),
    .o_done(done), .o_aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The controlled register.
  always @(posedge clk) begin
    if (reg_cl)       reg_q <= 4'h0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 4'h1;
    else if (reg_dec) reg_q <= reg_q - 4'h1;
    else if (reg_sr)  reg_q <= {reg_ir, reg_q[3:1]};
    else if (reg_sl)  reg_q <= {reg_q[2:0], reg_il};
  end

  // Abort is raised for the whole of its target cycle.
  always @(posedge clk) begin
    #1;
    abort = (cyc == abort_cyc);
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int cmd_len(input logic [2:0] op, input logic [3:0] data);
    if (op == 3'd0) return 0;
    if (op == 3'd1 || op == 3'd2) return 1;
    return int'(data);
  endfunction

  // Present a command, wait for acceptance, and queue its expected events.
  // ab_at: 0 = no abort, k = abort in the k-th cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [3:0] data,
                       input logic fill, input int ab_at, input bit hold);
    int n, ns, t, guard;
    bit abd;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_fill  = fill;
    guard = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        chk("ready_timeout", 0, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    t   = cyc;
    n   = cmd_len(op, data);
    abd = (n != 0) && (ab_at >= 1) && (ab_at <= n);
    ns  = abd ? ab_at - 1 : n;
    for (int i = 0; i < ns; i++) begin
      e = '{is_done: 0, cyc: t + 1 + i, strb: 6'b0, rin: 4'h0, ir: 0, il: 0,
            ab: 0, val: 4'h0};
      case (op)
        3'd1: begin e.strb = 6'b100000; mv = 0; end
        3'd2: begin e.strb = 6'b010000; e.rin = data; mv = int'(data); end
        3'd3: begin e.strb = 6'b001000; mv = (mv + 1) % 16; end
        3'd4: begin e.strb = 6'b000100; mv = (mv + 15) % 16; end
        3'd5: begin e.strb = 6'b000010; e.ir = fill; mv = mv / 2 + int'(fill) * 8; end
        3'd6: begin e.strb = 6'b000001; e.il = fill; mv = (mv * 2) % 16 + int'(fill); end
        default: begin
          e.strb = 6'b000010; e.ir = 1'(mv % 2); mv = mv / 2 + (mv % 2) * 8;
        end
      endcase
      sbq.push_back(e);
    end
    e = '{is_done: 1, cyc: t + (abd ? ab_at : n) + 1, strb: 6'b0, rin: 4'h0,
          ir: 0, il: 0, ab: abd, val: 4'(mv)};
    sbq.push_back(e);
    if (ab_at >= 1) abort_cyc = t + ab_at;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sbq.size() != 0 || !cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        chk("drain_timeout", 0, 1);
        sbq.delete();
        return;
      end
    end
  endtask

  // Monitor: pop and compare whenever strobes or done appear.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [5:0] s;
    logic [17:0] act, expv;
    if (!rst) begin
      s = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
      checks++;
      if ($countones(s) > 1 || (aborted && !done) ||
          (s == 6'b0 && (reg_in != 4'h0 || reg_ir || reg_il))) begin
        errors++;
        $display("FAIL output_rules got strb=%b in=%h ir=%b il=%b done=%b ab=%b",
                 s, reg_in, reg_ir, reg_il, done, aborted);
      end
      if (chk_ready_next) begin
        chk("ready_after_done", int'(cmd_ready), 1);
        chk_ready_next = 0;
      end
      if (s != 6'b0 || done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", int'({s, done}), 0);
        end else begin
          e = sbq.pop_front();
          act  = {done, s, reg_in, reg_ir, reg_il, done ? aborted : 1'b0,
                  done ? reg_q : 4'h0};
          expv = {e.is_done, e.strb, e.rin, e.ir, e.il, e.ab, e.val};
          chk("event_fields", int'(act), int'(expv));
          chk("event_cycle", cyc, e.cyc);
          if (done) begin
            chk("ready_during_done", int'(cmd_ready), 0);
            chk_ready_next = 1;
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        chk("missed_event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0;
    cmd_fill = 1'b0; abort = 1'b0;
    #12;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'({done, aborted}), 0);
    chk("rst_strobes", int'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}), 0);
    chk("rst_data", int'({reg_in, reg_ir, reg_il}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed sequences.
    issue(3'd2, 4'h9, 1'b0, 0, 0);          // LOAD 9
    wait_drain();
    issue(3'd2, 4'hE, 1'b0, 0, 0);          // LOAD E
    issue(3'd3, 4'd3, 1'b0, 0, 0);          // ADD 3 -> 1 (wrap)
    issue(3'd2, 4'h1, 1'b0, 0, 0);
    issue(3'd6, 4'd2, 1'b1, 0, 0);          // SHL 2 fill 1 -> 7
    issue(3'd7, 4'd1, 1'b0, 0, 0);          // ROR 1 -> B
    issue(3'd2, 4'h2, 1'b0, 0, 0);
    issue(3'd4, 4'd5, 1'b0, 3, 0);          // SUB 5, abort in 3rd EXEC cycle -> 0
    issue(3'd3, 4'd0, 1'b0, 0, 1);          // ADD 0 with valid held
    issue(3'd0, 4'h5, 1'b1, 0, 1);          // NOP with valid held
    issue(3'd1, 4'h3, 1'b0, 2, 1);          // CLR, abort lands in DONE (ignored)
    wait_drain();
    chk("reg_after_directed", int'(reg_q), 0);

    // Randomized commands.
    for (int k = 0; k < 300; k++) begin
      logic [2:0] op;
      logic [3:0] data;
      int ab;
      op   = 3'($urandom_range(0, 7));
      data = 4'($urandom_range(0, 15));
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cmd_len(op, data) + 1) : 0;
      issue(op, data, 1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    wait_drain();
    chk("reg_after_random", int'(reg_q), mv);

    // Reset in the middle of SHR 4.
    issue(3'd5, 4'd4, 1'b1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_strobe", int'({reg_sr, reg_ir}), 0);
    chk("rst_mid_done", int'(done), 0);
    sbq.delete();
    abort_cyc = -1;
    chk_ready_next = 0;
    @(negedge clk);
    chk("rst_hold_ready", int'({cmd_ready, done}), 2);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_release_ready", int'(cmd_ready), 1);
    issue(3'd1, 4'h0, 1'b0, 0, 0);          // CLR
    wait_drain();
    chk("reg_after_clr", int'(reg_q), 0);
    chk("queue_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
